// File: rtl/pong_rally_controller.sv
// Rally sequencer for one Pong ball: detects wall/paddle hits and misses,
// drives the bounce command, speed and ball run enable, and keeps both scores.
module pong_rally_controller #(
    parameter int SCREEN_X     = 640,
    parameter int SCREEN_Y     = 480,
    parameter int PADDLE_L_X   = 16,
    parameter int PADDLE_R_X   = 616,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_CYCLES = 1000,
    parameter int SPEED_INIT   = 4,
    parameter int SPEED_MIN    = 1,
    parameter int RALLY_STEP   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_size_x,
    input  logic [7:0] ball_size_y,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [1:0] bounce,
    output logic [2:0] speed,
    output logic       ball_run,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner
);

    // state     | meaning
    // IDLE      | waiting for start after reset
    // SERVE     | ball held at centre while the serve counter runs
    // PLAY      | ball moving; miss/paddle/wall detection active
    // ACK       | bounce held until the ball position changes
    // SCORE     | one cycle to decide between next serve and game over
    // GAME_OVER | final scores held until start
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_ACK,
        ST_SCORE,
        ST_GAME_OVER
    } state_t;

    localparam logic [1:0]  BOUNCE_NONE   = 2'b00;
    localparam logic [1:0]  BOUNCE_PADDLE = 2'b01;
    localparam logic [1:0]  BOUNCE_WALL   = 2'b10;
    localparam logic [10:0] L_FACE_X      = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] R_FACE_X      = 11'(PADDLE_R_X);
    localparam logic [10:0] LIMIT_X       = 11'(SCREEN_X);
    localparam logic [10:0] LIMIT_Y       = 11'(SCREEN_Y);
    localparam logic [10:0] PAD_H         = 11'(PADDLE_H);
    localparam logic [15:0] SERVE_LAST    = 16'(SERVE_CYCLES - 1);
    localparam logic [3:0]  HIT_LAST      = 4'(RALLY_STEP - 1);
    localparam logic [3:0]  WIN           = 4'(WIN_SCORE);
    localparam logic [2:0]  SPD_INIT      = 3'(SPEED_INIT);
    localparam logic [2:0]  SPD_MIN       = 3'(SPEED_MIN);

    state_t      state, state_next;
    logic [1:0]  bounce_next;
    logic [2:0]  speed_next;
    logic        ball_run_next;
    logic [3:0]  score_l_next, score_r_next;
    logic        game_over_next, winner_next;
    logic [3:0]  hit_cnt, hit_cnt_next;
    logic [15:0] serve_cnt, serve_cnt_next;
    logic [9:0]  lat_x, lat_x_next;
    logic [9:0]  lat_y, lat_y_next;
    logic        scored_r, scored_r_next;

    logic [10:0] ball_x_w, ball_y_w, sum_x, sum_y;
    logic [10:0] pad_l_top, pad_r_top;
    logic        miss_l, miss_r, hit_l, hit_r, wall, moved;

    // All geometry is done in 11 bits so edge sums never wrap.
    always_comb begin
        ball_x_w  = {1'b0, ball_x};
        ball_y_w  = {1'b0, ball_y};
        sum_x     = ball_x_w + {3'b000, ball_size_x};
        sum_y     = ball_y_w + {3'b000, ball_size_y};
        pad_l_top = {1'b0, paddle_l_y};
        pad_r_top = {1'b0, paddle_r_y};
        miss_l    = (ball_x == 10'd0);
        miss_r    = (sum_x >= LIMIT_X);
        hit_l     = (ball_x_w == L_FACE_X) &&
                    (ball_y_w < pad_l_top + PAD_H) && (sum_y > pad_l_top);
        hit_r     = (sum_x == R_FACE_X) &&
                    (ball_y_w < pad_r_top + PAD_H) && (sum_y > pad_r_top);
        wall      = (ball_y == 10'd0) || (sum_y >= LIMIT_Y);
        moved     = (ball_x != lat_x) || (ball_y != lat_y);
    end

    always_comb begin
        state_next     = state;
        bounce_next    = bounce;
        speed_next     = speed;
        ball_run_next  = ball_run;
        score_l_next   = score_l;
        score_r_next   = score_r;
        game_over_next = game_over;
        winner_next    = winner;
        hit_cnt_next   = hit_cnt;
        serve_cnt_next = serve_cnt;
        lat_x_next     = lat_x;
        lat_y_next     = lat_y;
        scored_r_next  = scored_r;

        case (state)
            ST_IDLE: begin
                ball_run_next = 1'b0;
                if (start) begin
                    score_l_next   = 4'd0;
                    score_r_next   = 4'd0;
                    serve_cnt_next = 16'd0;
                    state_next     = ST_SERVE;
                end
            end

            ST_SERVE: begin
                ball_run_next = 1'b0;
                bounce_next   = BOUNCE_NONE;
                speed_next    = SPD_INIT;
                hit_cnt_next  = 4'd0;
                if (serve_cnt == SERVE_LAST) begin
                    serve_cnt_next = 16'd0;
                    ball_run_next  = 1'b1;
                    state_next     = ST_PLAY;
                end else begin
                    serve_cnt_next = serve_cnt + 16'd1;
                end
            end

            ST_PLAY: begin
                ball_run_next = 1'b1;
                if (miss_l) begin
                    score_r_next  = score_r + 4'd1;
                    scored_r_next = 1'b1;
                    ball_run_next = 1'b0;
                    state_next    = ST_SCORE;
                end else if (miss_r) begin
                    score_l_next  = score_l + 4'd1;
                    scored_r_next = 1'b0;
                    ball_run_next = 1'b0;
                    state_next    = ST_SCORE;
                end else if (hit_l || hit_r) begin
                    bounce_next = BOUNCE_PADDLE;
                    lat_x_next  = ball_x;
                    lat_y_next  = ball_y;
                    state_next  = ST_ACK;
                end else if (wall) begin
                    bounce_next = BOUNCE_WALL;
                    lat_x_next  = ball_x;
                    lat_y_next  = ball_y;
                    state_next  = ST_ACK;
                end
            end

            ST_ACK: begin
                // The bounce register itself records whether this was a paddle ACK.
                if (moved) begin
                    bounce_next = BOUNCE_NONE;
                    state_next  = ST_PLAY;
                    if (bounce == BOUNCE_PADDLE) begin
                        if (hit_cnt == HIT_LAST) begin
                            hit_cnt_next = 4'd0;
                            if (speed > SPD_MIN)
                                speed_next = speed - 3'd1;
                        end else begin
                            hit_cnt_next = hit_cnt + 4'd1;
                        end
                    end
                end
            end

            ST_SCORE: begin
                ball_run_next = 1'b0;
                bounce_next   = BOUNCE_NONE;
                if ((scored_r ? score_r : score_l) == WIN) begin
                    game_over_next = 1'b1;
                    winner_next    = scored_r;
                    state_next     = ST_GAME_OVER;
                end else begin
                    serve_cnt_next = 16'd0;
                    state_next     = ST_SERVE;
                end
            end

            ST_GAME_OVER: begin
                ball_run_next  = 1'b0;
                game_over_next = 1'b1;
                if (start) begin
                    score_l_next   = 4'd0;
                    score_r_next   = 4'd0;
                    game_over_next = 1'b0;
                    serve_cnt_next = 16'd0;
                    state_next     = ST_SERVE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            bounce    <= BOUNCE_NONE;
            speed     <= SPD_INIT;
            ball_run  <= 1'b0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            hit_cnt   <= 4'd0;
            serve_cnt <= 16'd0;
            lat_x     <= 10'd0;
            lat_y     <= 10'd0;
            scored_r  <= 1'b0;
        end else begin
            state     <= state_next;
            bounce    <= bounce_next;
            speed     <= speed_next;
            ball_run  <= ball_run_next;
            score_l   <= score_l_next;
            score_r   <= score_r_next;
            game_over <= game_over_next;
            winner    <= winner_next;
            hit_cnt   <= hit_cnt_next;
            serve_cnt <= serve_cnt_next;
            lat_x     <= lat_x_next;
            lat_y     <= lat_y_next;
            scored_r  <= scored_r_next;
        end
    end

endmodule

// File: tb/tb_pong_rally_controller.sv
// Randomized rally bench: scores, hit count and speed are tracked as plain
// counters and every expectation is derived from the game rules.
module tb_pong_rally_controller;

    localparam int SCREEN_X     = 640;
    localparam int SCREEN_Y     = 480;
    localparam int PADDLE_L_X   = 16;
    localparam int PADDLE_R_X   = 616;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int WIN_SCORE    = 9;
    localparam int SERVE_CYCLES = 10;
    localparam int SPEED_INIT   = 4;
    localparam int SPEED_MIN    = 1;
    localparam int RALLY_STEP   = 4;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic [7:0] ball_size_x, ball_size_y;
    logic [1:0] bounce;
    logic [2:0] speed;
    logic       ball_run, game_over, winner;
    logic [3:0] score_l, score_r;

    int n_checks = 0;
    int n_errors = 0;
    int exp_l, exp_r, exp_hits;
    bit over;

    always #5 clock = ~clock;

    pong_rally_controller #(
        .SCREEN_X(SCREEN_X), .SCREEN_Y(SCREEN_Y), .PADDLE_L_X(PADDLE_L_X),
        .PADDLE_R_X(PADDLE_R_X), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
        .WIN_SCORE(WIN_SCORE), .SERVE_CYCLES(SERVE_CYCLES),
        .SPEED_INIT(SPEED_INIT), .SPEED_MIN(SPEED_MIN), .RALLY_STEP(RALLY_STEP)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .ball_x(ball_x), .ball_y(ball_y),
        .ball_size_x(ball_size_x), .ball_size_y(ball_size_y),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .bounce(bounce), .speed(speed), .ball_run(ball_run),
        .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .winner(winner)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_speed();
        int s;
        s = SPEED_INIT - exp_hits / RALLY_STEP;
        if (s < SPEED_MIN) s = SPEED_MIN;
        return s;
    endfunction

    task automatic set_safe();
        ball_x = 10'd300;
        ball_y = 10'd200;
    endtask

    task automatic check_scores(input string tag);
        check_val({tag, "_score_l"}, 16'(score_l), 16'(exp_l));
        check_val({tag, "_score_r"}, 16'(score_r), 16'(exp_r));
    endtask

    // Called after the edge that entered SERVE.
    task automatic do_serve();
        for (int i = 1; i < SERVE_CYCLES; i++) begin
            step();
            check_val("serve_hold", 16'(ball_run), 16'd0);
        end
        step();
        check_val("serve_release", 16'(ball_run), 16'd1);
        exp_hits = 0;
        check_val("serve_speed", 16'(speed), 16'(SPEED_INIT));
        check_val("serve_bounce", 16'(bounce), 16'd0);
        check_scores("serve");
    endtask

    task automatic start_game();
        set_safe();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_l = 0;
        exp_r = 0;
        check_val("start_run", 16'(ball_run), 16'd0);
        check_val("start_game_over", 16'(game_over), 16'd0);
        check_scores("start");
        do_serve();
    endtask

    task automatic idle_play(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom_range(0, 1));
            step();
            check_val("idle_run", 16'(ball_run), 16'd1);
            check_val("idle_bounce", 16'(bounce), 16'd0);
        end
        start = 1'b0;
    endtask

    task automatic wall_hit();
        bit top;
        int hold;
        top    = 1'($urandom_range(0, 1));
        ball_x = 10'($urandom_range(100, 500));
        ball_y = top ? 10'd0 : 10'(SCREEN_Y - int'(ball_size_y) + int'($urandom_range(0, 3)));
        step();
        check_val("wall_bounce", 16'(bounce), 16'd2);
        hold = $urandom_range(0, 4);
        for (int i = 0; i < hold; i++) begin
            step();
            check_val("wall_hold", 16'(bounce), 16'd2);
        end
        ball_y = top ? 10'd1 : 10'd200;
        step();
        check_val("wall_release", 16'(bounce), 16'd0);
        step();
        check_val("wall_play", 16'(bounce), 16'd0);
        set_safe();
    endtask

    task automatic paddle_hit(input bit right);
        int py, lo, hi, hold;
        py = $urandom_range(20, 380);
        if (right) paddle_r_y = 10'(py); else paddle_l_y = 10'(py);
        lo = py - int'(ball_size_y) + 1;
        hi = py + PADDLE_H - 1;
        ball_y = 10'($urandom_range(lo, hi));
        ball_x = right ? 10'(PADDLE_R_X - int'(ball_size_x)) : 10'(PADDLE_L_X + PADDLE_W);
        step();
        check_val("paddle_bounce", 16'(bounce), 16'd1);
        hold = $urandom_range(0, 4);
        for (int i = 0; i < hold; i++) begin
            step();
            check_val("paddle_hold", 16'(bounce), 16'd1);
        end
        ball_x = right ? ball_x - 10'd1 : ball_x + 10'd1;
        step();
        exp_hits++;
        check_val("paddle_release", 16'(bounce), 16'd0);
        check_val("paddle_speed", 16'(speed), 16'(exp_speed()));
        set_safe();
    endtask

    // Ball at a paddle face but just outside the vertical overlap window.
    task automatic near_miss(input bit right);
        int py;
        py = $urandom_range(20, 380);
        if (right) paddle_r_y = 10'(py); else paddle_l_y = 10'(py);
        ball_y = $urandom_range(0, 1) ? 10'(py + PADDLE_H) : 10'(py - int'(ball_size_y));
        ball_x = right ? 10'(PADDLE_R_X - int'(ball_size_x)) : 10'(PADDLE_L_X + PADDLE_W);
        step();
        check_val("near_miss_bounce", 16'(bounce), 16'd0);
        set_safe();
    endtask

    task automatic miss(input bit right, output bit finished);
        int sc;
        ball_x = right ? 10'(SCREEN_X - int'(ball_size_x) + int'($urandom_range(0, 3))) : 10'd0;
        ball_y = 10'($urandom_range(50, 400));
        step();
        if (right) exp_l++; else exp_r++;
        sc = right ? exp_l : exp_r;
        check_scores("miss");
        check_val("miss_run", 16'(ball_run), 16'd0);
        check_val("miss_bounce", 16'(bounce), 16'd0);
        set_safe();
        step();
        finished = (sc == WIN_SCORE);
        if (finished) begin
            check_val("over_flag", 16'(game_over), 16'd1);
            check_val("over_winner", 16'(winner), right ? 16'd0 : 16'd1);
            check_val("over_run", 16'(ball_run), 16'd0);
        end else begin
            check_val("score_game_over", 16'(game_over), 16'd0);
            check_val("score_run", 16'(ball_run), 16'd0);
            do_serve();
        end
    endtask

    task automatic random_event(output bit finished);
        int r;
        finished = 1'b0;
        r = $urandom_range(0, 9);
        if (r < 2)      wall_hit();
        else if (r < 5) paddle_hit(1'($urandom_range(0, 1)));
        else if (r < 6) near_miss(1'($urandom_range(0, 1)));
        else if (r < 7) idle_play(int'($urandom_range(1, 3)));
        else            miss(1'($urandom_range(0, 1)), finished);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ball_size_x = 8'd8;
        ball_size_y = 8'd8;
        paddle_l_y = 10'd200;
        paddle_r_y = 10'd200;
        exp_l = 0;
        exp_r = 0;
        exp_hits = 0;
        set_safe();
        step();
        step();
        check_val("rst_bounce", 16'(bounce), 16'd0);
        check_val("rst_speed", 16'(speed), 16'(SPEED_INIT));
        check_val("rst_run", 16'(ball_run), 16'd0);
        check_scores("rst");
        check_val("rst_game_over", 16'(game_over), 16'd0);
        check_val("rst_winner", 16'(winner), 16'd0);
        reset = 1'b0;
        step();
        check_val("idle_run_low", 16'(ball_run), 16'd0);

        start_game();
        wall_hit();
        for (int i = 0; i < 16; i++) paddle_hit(1'(i % 2));
        check_val("speed_saturated", 16'(speed), 16'(SPEED_MIN));

        // Corner: paddle wins first, wall fires after the ACK.
        ball_x = 10'(PADDLE_L_X + PADDLE_W);
        ball_y = 10'd0;
        paddle_l_y = 10'd0;
        step();
        check_val("corner_paddle", 16'(bounce), 16'd1);
        ball_x = ball_x + 10'd1;
        step();
        exp_hits++;
        check_val("corner_release", 16'(bounce), 16'd0);
        step();
        check_val("corner_wall", 16'(bounce), 16'd2);
        ball_y = 10'd1;
        step();
        check_val("corner_wall_release", 16'(bounce), 16'd0);
        set_safe();

        over = 1'b0;
        for (int i = 0; i < 200 && !over; i++) random_event(over);
        check_val("game1_over", 16'(over), 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("over_hold", 16'(game_over), 16'd1);
            check_scores("over_hold");
        end

        ball_size_x = 8'($urandom_range(4, 16));
        ball_size_y = 8'($urandom_range(4, 16));
        start_game();
        for (int i = 0; i < 20; i++) begin
            random_event(over);
            if (over) start_game();
        end

        // Reset while holding a paddle bounce.
        paddle_l_y = 10'd200;
        ball_x = 10'(PADDLE_L_X + PADDLE_W);
        ball_y = 10'd210;
        step();
        check_val("pre_reset_bounce", 16'(bounce), 16'd1);
        reset = 1'b1;
        step();
        exp_l = 0;
        exp_r = 0;
        check_val("ack_rst_bounce", 16'(bounce), 16'd0);
        check_val("ack_rst_run", 16'(ball_run), 16'd0);
        check_val("ack_rst_speed", 16'(speed), 16'(SPEED_INIT));
        check_scores("ack_rst");
        reset = 1'b0;
        set_safe();

        // Reset part-way through a serve returns to IDLE.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < SERVE_CYCLES + 2; i++) begin
            step();
            check_val("serve_rst_idle", 16'(ball_run), 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
